// File: rtl/mips16_trace_capture.sv
// Trace capture for the mips_16 observation port: samples {pc, alu} each cycle,
// buffers the samples in a FIFO, streams them on valid/ready and stops on a PC self-loop.
module mips16_trace_capture #(
    parameter int DEPTH         = 16,
    parameter int HALT_CYCLES   = 4,
    parameter int FILTER_REPEAT = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [15:0]                pc_out,
    input  logic [15:0]                alu_result,
    input  logic                       cap_en,
    input  logic                       clear,
    output logic [31:0]                trace_data,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic                       halted,
    output logic                       overflow,
    output logic [7:0]                 drop_count,
    output logic [$clog2(DEPTH):0]     level
);

    // state     | meaning
    // S_IDLE    | not sampling; FIFO still drains
    // S_CAPTURE | sampling while cap_en=1, watching for a frozen PC
    // S_HALTED  | PC self-loop seen; waits for clear
    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_HALTED} state_t;

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(HALT_CYCLES) + 1;
    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
    localparam logic [CW-1:0] HALT_LAST = CW'(HALT_CYCLES - 2);

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q, level_d;
    logic [31:0]     mem_q [DEPTH];
    logic [15:0]     prev_pc_q;
    logic            sampled_q;
    logic [CW-1:0]   same_cnt_q, same_cnt_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      drop_q, drop_d;

    logic sample, is_repeat, push_cand, pop, full, push, drop, halt_hit;

    // A repeat needs an uninterrupted sampling history; the first sample after IDLE never is one.
    assign sample    = (state_q == S_CAPTURE) && cap_en;
    assign is_repeat = sample && sampled_q && (pc_out == prev_pc_q);
    assign push_cand = sample && (!is_repeat || (FILTER_REPEAT == 0));
    assign pop       = (level_q != '0) && trace_ready;
    assign full      = (level_q == FULL_LVL);
    assign push      = push_cand && (!full || pop);
    assign drop      = push_cand && full && !pop;
    assign halt_hit  = is_repeat && !clear && (same_cnt_q == HALT_LAST);

    always_comb begin
        state_d    = state_q;
        same_cnt_d = '0;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        level_d    = level_q;

        case (state_q)
            S_IDLE:    if (cap_en && !clear) state_d = S_CAPTURE;
            S_CAPTURE: begin
                if (!clear) begin
                    if (!cap_en)       state_d = S_IDLE;
                    else if (halt_hit) state_d = S_HALTED;
                end
            end
            S_HALTED:  if (clear) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        if (!clear && is_repeat) same_cnt_d = same_cnt_q + CW'(1);

        if (clear) begin
            overflow_d = 1'b0;
            drop_d     = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            prev_pc_q  <= '0;
            sampled_q  <= 1'b0;
            same_cnt_q <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            same_cnt_q <= same_cnt_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            sampled_q  <= sample;
            if (sample) prev_pc_q <= pc_out;
            if (push)   wr_ptr_q  <= wr_ptr_q + AW'(1);
            if (pop)    rd_ptr_q  <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {pc_out, alu_result};
    end

    assign trace_valid = (level_q != '0);
    assign trace_data  = trace_valid ? mem_q[rd_ptr_q] : 32'h0;
    assign halted      = (state_q == S_HALTED);
    assign overflow    = overflow_q;
    assign drop_count  = drop_q;
    assign level       = level_q;

endmodule

// File: tb/tb_mips16_trace_capture.sv
// Bench for mips16_trace_capture: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mips16_trace_capture;

    localparam int DEPTH         = 16;
    localparam int HALT_CYCLES   = 4;
    localparam int FILTER_REPEAT = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pc_out = '0;
    logic [15:0] alu_result = '0;
    logic        cap_en = 1'b0;
    logic        clear = 1'b0;
    logic        trace_ready = 1'b0;
    logic [31:0] trace_data;
    logic        trace_valid;
    logic        halted;
    logic        overflow;
    logic [7:0]  drop_count;
    logic [4:0]  level;

    mips16_trace_capture #(
        .DEPTH(DEPTH), .HALT_CYCLES(HALT_CYCLES), .FILTER_REPEAT(FILTER_REPEAT)
    ) dut (
        .clk(clk), .reset(reset), .pc_out(pc_out), .alu_result(alu_result),
        .cap_en(cap_en), .clear(clear), .trace_data(trace_data),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .halted(halted),
        .overflow(overflow), .drop_count(drop_count), .level(level)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: mode 0 = idle, 1 = capturing, 2 = halted.
    logic [31:0] mq[$];
    int          m_mode = 0;
    int          m_run = 0;
    int          m_drops = 0;
    logic [15:0] m_prev = '0;
    bit          m_had = 0;
    bit          m_ovf = 0;
    bit          smp, rep, cand, hlt;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_mode = 0; m_run = 0; m_drops = 0; m_prev = '0; m_had = 0; m_ovf = 0;
        end else begin
            smp  = (m_mode == 1) && cap_en;
            rep  = smp && m_had && (pc_out == m_prev);
            cand = smp && !(rep && FILTER_REPEAT != 0);
            if (mq.size() > 0 && trace_ready) void'(mq.pop_front());
            if (cand) begin
                if (mq.size() < DEPTH) mq.push_back({pc_out, alu_result});
                else begin
                    m_ovf = 1;
                    if (m_drops < 255) m_drops++;
                end
            end
            if (clear) begin
                m_ovf = 0;
                m_drops = 0;
            end
            hlt   = rep && !clear && (m_run + 1 >= HALT_CYCLES - 1);
            m_run = (rep && !clear) ? m_run + 1 : 0;
            if (smp) m_prev = pc_out;
            m_had = smp;
            if (clear) begin
                if (m_mode == 2) m_mode = 0;
            end else if (m_mode == 0) begin
                if (cap_en) m_mode = 1;
            end else if (m_mode == 1) begin
                if (!cap_en) m_mode = 0;
                else if (hlt) m_mode = 2;
            end
        end
    end

    always @(negedge clk) begin
        #1;
        chk("m_valid", {31'b0, trace_valid}, {31'b0, mq.size() != 0});
        if (mq.size() != 0) chk("m_data", trace_data, mq[0]);
        chk("m_level", {27'b0, level}, mq.size());
        chk("m_halted", {31'b0, halted}, {31'b0, m_mode == 2});
        chk("m_overflow", {31'b0, overflow}, {31'b0, m_ovf});
        chk("m_drops", {24'b0, drop_count}, m_drops);
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #2;
    endtask

    logic [31:0] exp1 [4];

    initial begin
        exp1 = '{32'h00000011, 32'h00020012, 32'h00040013, 32'h00060014};
        #1 reset = 1'b0;
        cyc();
        cyc();
        chk("rst_data", trace_data, 32'h0);
        chk("rst_valid", {31'b0, trace_valid}, 32'd0);
        chk("rst_level", {27'b0, level}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);
        chk("rst_drops", {24'b0, drop_count}, 32'd0);

        // Basic stream, one-cycle latency, ready held high
        reset = 1'b1; cap_en = 1'b1; trace_ready = 1'b1;
        cyc();
        chk("t1_no_sample_on_entry", {27'b0, level}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            pc_out = 16'(2 * i); alu_result = 16'(16'h0011 + i);
            cyc();
            chk("t1_valid", {31'b0, trace_valid}, 32'd1);
            chk("t1_word", trace_data, exp1[i]);
        end
        chk("t1_halted", {31'b0, halted}, 32'd0);
        cap_en = 1'b0;
        cyc();
        chk("t1_drained", {27'b0, level}, 32'd0);

        // Repeat filter and halt detection
        trace_ready = 1'b0; cap_en = 1'b1;
        cyc();
        pc_out = 16'h0010; alu_result = 16'h000A; cyc();
        pc_out = 16'h0012; alu_result = 16'h000B; cyc();
        for (int k = 0; k < 3; k++) begin
            alu_result = 16'(16'h000C + k);
            cyc();
            if (k < 2) chk("t2_not_halted_yet", {31'b0, halted}, 32'd0);
        end
        chk("t2_halted", {31'b0, halted}, 32'd1);
        chk("t2_two_pushes", {27'b0, level}, 32'd2);
        pc_out = 16'h0020;
        cyc(); cyc(); cyc();
        chk("t2_no_push_halted", {27'b0, level}, 32'd2);
        chk("t2_still_halted", {31'b0, halted}, 32'd1);
        cap_en = 1'b0; clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("t2_clear", {31'b0, halted}, 32'd0);
        pc_out = 16'h0030;
        cyc();
        chk("t2_idle_no_push", {27'b0, level}, 32'd2);
        trace_ready = 1'b1;
        chk("t2_word0", trace_data, 32'h0010000A);
        cyc();
        chk("t2_word1", trace_data, 32'h0012000B);
        cyc();
        chk("t2_empty", {27'b0, level}, 32'd0);
        trace_ready = 1'b0;

        // Overflow with 20 samples, then drain in order
        cap_en = 1'b1;
        cyc();
        for (int i = 0; i < 20; i++) begin
            pc_out = 16'(16'h0100 + 2 * i); alu_result = 16'(16'hA000 + i);
            cyc();
        end
        chk("t3_level", {27'b0, level}, 32'd16);
        chk("t3_ovf", {31'b0, overflow}, 32'd1);
        chk("t3_drops", {24'b0, drop_count}, 32'd4);
        cap_en = 1'b0;
        cyc();
        trace_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t3_drain", trace_data, {16'(16'h0100 + 2 * i), 16'(16'hA000 + i)});
            cyc();
        end
        chk("t3_level0", {27'b0, level}, 32'd0);
        trace_ready = 1'b0;

        // Full FIFO with simultaneous push and pop
        cap_en = 1'b1;
        cyc();
        for (int i = 0; i < 16; i++) begin
            pc_out = 16'(16'h0300 + 2 * i); alu_result = 16'(i);
            cyc();
        end
        chk("t4_full", {27'b0, level}, 32'd16);
        trace_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pc_out = 16'(16'h0400 + 2 * i); alu_result = 16'(i);
            cyc();
            chk("t4_level", {27'b0, level}, 32'd16);
            chk("t4_drops", {24'b0, drop_count}, 32'd4);
        end
        cap_en = 1'b0;
        for (int i = 0; i < 20; i++) cyc();
        chk("t4_drained", {27'b0, level}, 32'd0);
        trace_ready = 1'b0;

        // Drop counter saturation, then clear keeps the FIFO
        cap_en = 1'b1;
        cyc();
        for (int i = 0; i < 316; i++) begin
            pc_out = 16'(16'h1000 + 2 * i); alu_result = 16'(i);
            cyc();
        end
        chk("t5_sat", {24'b0, drop_count}, 32'd255);
        chk("t5_ovf", {31'b0, overflow}, 32'd1);
        cap_en = 1'b0;
        cyc();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("t5_clr_ovf", {31'b0, overflow}, 32'd0);
        chk("t5_clr_drops", {24'b0, drop_count}, 32'd0);
        chk("t5_kept", {27'b0, level}, 32'd16);

        // Asynchronous reset with 5 entries buffered
        trace_ready = 1'b1;
        for (int i = 0; i < 11; i++) cyc();
        trace_ready = 1'b0;
        chk("t6_level5", {27'b0, level}, 32'd5);
        reset = 1'b0;
        #1;
        chk("t6_valid", {31'b0, trace_valid}, 32'd0);
        chk("t6_level", {27'b0, level}, 32'd0);
        chk("t6_halted", {31'b0, halted}, 32'd0);
        cyc();
        reset = 1'b1;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cap_en      = ($urandom_range(0, 9) != 0);
            clear       = ($urandom_range(0, 49) == 0);
            trace_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) pc_out = 16'($urandom_range(0, 7) * 2);
            alu_result  = 16'($urandom);
            cyc();
        end
        clear = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mips16_trace_capture.md
Name: mips16_trace_capture

Overview:
- Consumer at the far end of the CPU observation interface: samples the single-cycle core's `pc_out`/`alu_result` stream every clock and buffers the samples.
- Streams buffered samples out as 32-bit trace words on a valid/ready port.
- Detects a self-loop halt (PC frozen) and stops capturing.
- Sits beside `mips_16` in the top level, for on-chip execution tracing and bench scoreboarding.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- HALT_CYCLES, 4, consecutive cycles of unchanged `pc_out` that declare a halt; at least 2.
- FILTER_REPEAT, 1, when 1 a sample whose PC equals the previous cycle's PC is not pushed.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted); one clock domain.
- pc_out  input  16  core program counter, sampled every cycle.
- alu_result  input  16  core ALU result, sampled every cycle.
- cap_en  input  1  level; enables capture from IDLE.
- clear  input  1  one-cycle pulse; returns from HALTED to IDLE and clears flags and counters.
- trace_data  output  32  {pc[15:0], alu[15:0]} at the FIFO head.
- trace_valid  output  1  FIFO non-empty.
- trace_ready  input  1  consumer pops the head when trace_valid=1 and trace_ready=1.
- halted  output  1  high while in HALTED.
- overflow  output  1  sticky; a sample was dropped because the FIFO was full.
- drop_count  output  8  saturating count of dropped samples.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; FIFO empty; trace_valid=0; trace_data=0; halted=0; overflow=0; drop_count=0; level=0; prev_pc=0; same_cnt=0.
- IDLE -> CAPTURE on an edge with cap_en=1. Nothing is sampled on the transition edge.
- CAPTURE, every edge:
  - A sample is "repeat" if pc_out==prev_pc and the previous edge was also in CAPTURE. The first CAPTURE cycle is never a repeat.
  - If the sample is not a repeat, or FILTER_REPEAT=0, it is a push candidate.
  - prev_pc <= pc_out on every CAPTURE edge.
- Halt detection:
  - same_cnt increments on each repeat sample and clears on each non-repeat sample.
  - When same_cnt reaches HALT_CYCLES-1 and the current sample is a repeat, move to HALTED and set halted=1 on that edge.
  - That final repeat sample is still subject to the filter rule.
- CAPTURE -> IDLE when cap_en=0. FIFO contents are kept; same_cnt is cleared.
- HALTED: no sampling. The FIFO keeps draining. Only `clear` (or reset) leaves HALTED, going to IDLE.
- `clear` in IDLE or CAPTURE: zeroes overflow, drop_count and same_cnt; the state is unchanged.
- `clear` never flushes the FIFO.
- FIFO:
  - A push candidate written at edge N appears at trace_data with trace_valid=1 in the cycle after edge N when the FIFO was empty (one-cycle latency).
  - No same-cycle bypass.
  - trace_data holds the head entry while trace_valid=1, and is don't-care when empty.
- Full FIFO:
  - Push and pop on the same edge: both occur, nothing is dropped, level is unchanged.
  - Push without pop: the sample is dropped, overflow<=1, and drop_count increments, saturating at 255.
- Empty FIFO: trace_ready is ignored and level stays 0.
- Pointers wrap modulo DEPTH. level = write count minus read count; it never exceeds DEPTH.
- Reset mid-operation: all state is discarded immediately; buffered entries are lost.

Test Plan:
- Reset, cap_en=1, pc_out steps 0,2,4,6 with alu 0x0011..0x0014, trace_ready=1 -> trace words 0x00000011, 0x00020012, 0x00040013, 0x00060014 in order, one cycle after each sample; halted=0.
- FILTER_REPEAT=1, pc_out 0x0010,0x0012 then held at 0x0012 -> exactly two words pushed; halted rises on the 4th consecutive 0x0012 sample (3 repeats, HALT_CYCLES=4); no further pushes; clear -> halted=0, state IDLE.
- trace_ready=0, 20 distinct PCs -> level=16, overflow=1, drop_count=4; then drain -> the first 16 samples in order, level returns to 0.
- FIFO full with trace_ready=1 and distinct PCs streaming -> no drops, level stays 16, drop_count unchanged.
- 300 drops with trace_ready=0 -> drop_count saturates at 255; clear -> overflow=0, drop_count=0, FIFO still holds 16 entries.
- Assert reset=0 mid-stream with level=5 -> trace_valid=0, level=0, halted=0 immediately, without waiting for a clock edge.
